// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined SECDED Hamming codec (encode / decode+correct) with saturating error counters.
// Optional macro HAMMING_ERR_INJECT_EN adds a one-shot single-bit error injector on encode results.
module hamming_secded_codec #(
    parameter  int DATA_W = 26,
    parameter  int CNT_W  = 16,
    localparam int P_W    = (DATA_W <= 32'sd4)  ? 32'sd3 :
                            (DATA_W <= 32'sd11) ? 32'sd4 :
                            (DATA_W <= 32'sd26) ? 32'sd5 :
                            (DATA_W <= 32'sd57) ? 32'sd6 : 32'sd7,
    localparam int CODE_W = DATA_W + P_W + 32'sd1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic                      inj_arm,
    input  logic [$clog2(CODE_W)-1:0] inj_pos
`endif
);

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_CORR   = 2'b01;
    localparam logic [1:0] ST_UNCORR = 2'b10;

    // Data bits occupy the non-power-of-two Hamming positions in ascending order.
    function automatic logic [CODE_W-1:0] place_data(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int                j;
        c = '0;
        j = 32'sd0;
        for (int k = 32'sd1; k < CODE_W; k++) begin
            if ((k & (k - 32'sd1)) != 32'sd0) begin
                c[k-1] = d[j];
                j++;
            end else begin
                c[k-1] = 1'b0;
            end
        end
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 32'sd0;
        for (int k = 32'sd1; k < CODE_W; k++) begin
            if ((k & (k - 32'sd1)) != 32'sd0) begin
                d[j] = c[k-1];
                j++;
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    // XOR of the positions of all set bits: parity bits for a data-only word, error position otherwise.
    function automatic logic [P_W-1:0] syndrome(input logic [CODE_W-1:0] c);
        logic [P_W-1:0] s;
        s = '0;
        for (int k = 32'sd1; k < CODE_W; k++) begin
            if (c[k-1]) begin
                s = s ^ P_W'(k);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic              s1_mode_q, s1_mode_d;
    logic [CODE_W-1:0] s1_word_q, s1_word_d;
    logic [P_W-1:0]    s1_syn_q, s1_syn_d;
    logic              s1_op_q, s1_op_d;
    logic              s2_valid_q, s2_valid_d;
    logic [CODE_W-1:0] out_code_q, out_code_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_status_q, out_status_d;
    logic [CNT_W-1:0]  corr_q, corr_d;
    logic [CNT_W-1:0]  uncorr_q, uncorr_d;
`ifdef HAMMING_ERR_INJECT_EN
    logic              inj_flag_q, inj_flag_d;
`endif

    logic              s2_ready_s, in_ready_s, in_fire_s, out_fire_s, syn_in_range_s;
    logic [CODE_W-1:0] in_code_s, fix_code_s;
    logic [1:0]        fix_status_s;

    // Handshake, stage-1 capture, stage-2 correction and counter next-state logic.
    always_comb begin
        s2_ready_s = !s2_valid_q || out_ready;
        in_ready_s = !s1_valid_q || s2_ready_s;
        in_fire_s  = in_valid && in_ready_s;
        out_fire_s = s2_valid_q && out_ready;

        in_code_s  = in_mode ? in_word : place_data(in_word[DATA_W-1:0]);
        s1_mode_d  = s1_mode_q;
        s1_word_d  = s1_word_q;
        s1_syn_d   = s1_syn_q;
        s1_op_d    = s1_op_q;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            s1_mode_d  = in_mode;
            s1_word_d  = in_code_s;
            s1_syn_d   = syndrome(in_code_s);
            s1_op_d    = ^in_code_s;
        end else if (s2_ready_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        syn_in_range_s = ({{(32-P_W){1'b0}}, s1_syn_q} < 32'(CODE_W));
        fix_code_s     = s1_word_q;
        fix_status_s   = ST_CLEAN;
        if (!s1_mode_q) begin
            for (int i = 32'sd0; i < P_W; i++) begin
                fix_code_s[(32'sd1 << i) - 32'sd1] = s1_syn_q[i];
            end
            fix_code_s[CODE_W-1] = ^fix_code_s[CODE_W-2:0];
        end else if (s1_syn_q == '0) begin
            if (s1_op_q) begin
                fix_code_s[CODE_W-1] = ~s1_word_q[CODE_W-1];
                fix_status_s         = ST_CORR;
            end else begin
                fix_status_s = ST_CLEAN;
            end
        end else if (s1_op_q && syn_in_range_s) begin
            fix_code_s   = s1_word_q ^ ({{(CODE_W-1){1'b0}}, 1'b1} << (s1_syn_q - {{(P_W-1){1'b0}}, 1'b1}));
            fix_status_s = ST_CORR;
        end else begin
            fix_status_s = ST_UNCORR;
        end

`ifdef HAMMING_ERR_INJECT_EN
        inj_flag_d = inj_flag_q;
        if (s1_valid_q && s2_ready_s && !s1_mode_q && inj_flag_q) begin
            inj_flag_d = 1'b0;
            if ({{(32-$clog2(CODE_W)){1'b0}}, inj_pos} < 32'(CODE_W)) begin
                fix_code_s = fix_code_s ^ ({{(CODE_W-1){1'b0}}, 1'b1} << inj_pos);
            end else begin
                fix_code_s = fix_code_s;
            end
        end else begin
            inj_flag_d = inj_flag_q;
        end
        if (inj_arm) begin
            inj_flag_d = 1'b1;
        end else begin
            inj_flag_d = inj_flag_d;
        end
`endif

        // Output registers only move when a new word enters, so a stalled result stays stable.
        s2_valid_d   = s2_valid_q;
        out_code_d   = out_code_q;
        out_data_d   = out_data_q;
        out_status_d = out_status_q;
        if (s2_ready_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_code_d   = fix_code_s;
                out_data_d   = extract_data(fix_code_s);
                out_status_d = fix_status_s;
            end else begin
                out_code_d = out_code_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (cnt_clr) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (out_fire_s) begin
            case (out_status_q)
                ST_CORR:   corr_d   = (&corr_q)   ? corr_q   : corr_q + CNT_W'(1);
                ST_UNCORR: uncorr_d = (&uncorr_q) ? uncorr_q : uncorr_q + CNT_W'(1);
                default:   corr_d   = corr_q;
            endcase
        end else begin
            corr_d = corr_q;
        end
    end

    // Pipeline and counter state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_word_q    <= '0;
            s1_syn_q     <= '0;
            s1_op_q      <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_code_q   <= '0;
            out_data_q   <= '0;
            out_status_q <= 2'b00;
            corr_q       <= '0;
            uncorr_q     <= '0;
`ifdef HAMMING_ERR_INJECT_EN
            inj_flag_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mode_q    <= s1_mode_d;
            s1_word_q    <= s1_word_d;
            s1_syn_q     <= s1_syn_d;
            s1_op_q      <= s1_op_d;
            s2_valid_q   <= s2_valid_d;
            out_code_q   <= out_code_d;
            out_data_q   <= out_data_d;
            out_status_q <= out_status_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
`ifdef HAMMING_ERR_INJECT_EN
            inj_flag_q   <= inj_flag_d;
`endif
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = s2_valid_q;
    assign out_code     = out_code_q;
    assign out_data     = out_data_q;
    assign out_status   = out_status_q;
    assign corr_count   = corr_q;
    assign uncorr_count = uncorr_q;

endmodule

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
- Parametrised SECDED Hamming codec, successor to the fixed 26-bit encoder.
- Per-transaction mode selects one of two operations:
  - encode: DATA_W data bits to a CODE_W codeword.
  - decode/correct: CODE_W codeword back to data, with error status.
- Two-stage pipeline with valid/ready on both sides. Saturating corrected/uncorrectable error counters.
- Sits between the datapath and storage/link: encode on write, decode on read.

Parameters:
- DATA_W, 26, data bits per word (2..57).
- P_W, derived (localparam), smallest P with 2**P >= DATA_W+P+1. It is 5 for DATA_W=26.
- CODE_W, derived (localparam), DATA_W+P_W+1. It is 32 for DATA_W=26.
- CNT_W, 16, width of each error counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input
- in_mode  in  1  0 = encode, 1 = decode
- in_word  in  CODE_W  encode: data in [DATA_W-1:0], upper bits ignored; decode: codeword
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_code  out  CODE_W  encoded codeword (encode); corrected codeword (decode)
- out_data  out  DATA_W  extracted data (decode); copy of input data (encode)
- out_status  out  2  00 clean, 01 corrected single, 10 uncorrectable, 11 reserved (never driven)
- cnt_clr  in  1  synchronous clear of both counters
- corr_count  out  CNT_W  corrected-error count
- uncorr_count  out  CNT_W  uncorrectable-error count

Behaviour:
- Reset is fixed: one clock; reset is synchronous and active-low.
- Reset values (reset_n low at a clock edge):
  - both stage valids 0, so out_valid=0;
  - out_code, out_data, out_status, corr_count, uncorr_count all 0;
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards in-flight words. No output transfer occurs for them and counters do not change.
- Codeword layout:
  - Hamming position k (1..CODE_W-1) maps to bit k-1.
  - Parity p(2^i) sits at bit 2^i-1.
  - Data bits fill the remaining positions in ascending order. For DATA_W=26, d0 is at bit 2.
  - The overall-parity bit is bit CODE_W-1 and makes the XOR of the full codeword 0.
  - p(2^i) is the XOR of the data bits whose position has bit i set.
- Pipeline:
  - Stage 1 registers mode, word, the Hamming syndrome (P_W bits) and the overall parity. For encode, it registers the computed parity bits.
  - Stage 2 registers correction and the outputs.
- Handshake and latency:
  - Latency is 2 cycles from the input transfer to out_valid, when out_ready=1. Throughput is 1 word/cycle.
  - A stage advances when it is empty or its downstream transfers in the same cycle.
  - in_ready = !s1_valid || s1_advances.
  - Capacity is 2 words; with out_ready=0, in_ready falls after 2 accepts.
  - While out_valid=1 and out_ready=0, out_* stay stable.
- Decode classification (S = syndrome, OP = overall parity of the received word):
  - S=0, OP=0: clean, status 00.
  - S=0, OP=1: overall bit flipped. Correct bit CODE_W-1; status 01.
  - S!=0, OP=1, S<=CODE_W-1: flip bit S-1; status 01.
  - S!=0, OP=0: double error. No correction; status 10; out_data taken from the raw word.
  - S>CODE_W-1 (impossible position): status 10, no correction.
- Encode results: out_status=00 always, and counters are unaffected.
- Counters:
  - They update only on an output transfer (out_valid && out_ready).
  - Status 01 increments corr_count; status 10 increments uncorr_count.
  - Both saturate at all-ones.
  - cnt_clr wins over a same-cycle increment, so the result is 0.

Optional Feature:
- Macro: HAMMING_ERR_INJECT_EN.
- Defined: adds ports inj_arm (in, 1) and inj_pos (in, log2(CODE_W)).
  - A one-shot inject flag is set by inj_arm.
  - The next encode output transfer XORs bit inj_pos into out_code, then clears the flag.
  - inj_pos >= CODE_W clears the flag with no flip.
  - The flag is cleared by reset.
- Undefined: ports absent; out_code is always the exact encoding.

Test Plan (DATA_W=26):
- Encode data 26'h0 -> out_code 32'h00000000, status 00, out_valid 2 cycles after accept.
- Encode 26'h1 -> out_code 32'h80000007 (p1=1, p2=1, d0=1, overall=1).
- Decode 32'h80000407 (bit 10 flipped) -> out_code 32'h80000007, out_data 26'h1, status 01, corr_count=1. Decode 32'h00000007 (bit 31 flipped) -> out_data 26'h1, status 01, corr_count=2.
- Decode 32'h80000004 (bits 0,1 flipped) -> status 10, out_code unchanged, uncorr_count=1. Then pulse cnt_clr with a simultaneous status-10 transfer -> both counters 0.
- out_ready=0 for 6 cycles while offering 4 words:
  - 2 words accepted, then in_ready=0 and out_* stable.
  - After out_ready=1, all 4 words emerge in order, 1 per cycle.
- reset_n=0 for one edge with 2 words in flight -> out_valid=0 and counters 0 next cycle; in_ready=1; no stale output appears afterwards.
